// File: rtl/rtc_bus_pkg.sv
// Shared definitions for the RTC multiplexed AD bus read/write blocks.
// States, default timings and fixed bus codes.
package rtc_bus_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ADDR = 3'd1,
        HOLD = 3'd2,
        TURN = 3'd3,
        READ = 3'd4,
        REC  = 3'd5
    } state_t;

    localparam int T_ADDR_D = 4;
    localparam int T_RD_D   = 10;
    localparam int T_REC_D  = 4;
    localparam int CNT_W_D  = 5;

    localparam logic [7:0] BUS_IDLE = 8'h00;
    localparam logic [7:0] BCD_INV  = 8'hFF;

endpackage

// File: rtl/rtc_bcd2bin.sv
// Combinational packed-BCD to binary converter.
// Invalid digits (>9) map to the BCD_INV code.
module rtc_bcd2bin
    import rtc_bus_pkg::*;
(
    input  logic [7:0] i_bcd,
    output logic [7:0] o_bin
);

    logic [3:0] w_hi;
    logic [3:0] w_lo;

    assign w_hi = i_bcd[7:4];
    assign w_lo = i_bcd[3:0];

    // tens*10 = tens*8 + tens*2
    always_comb begin
        o_bin = BCD_INV;
        if (w_hi <= 4'd9 && w_lo <= 4'd9) begin
            o_bin = {1'b0, w_hi, 3'b000}
                  + {3'b000, w_hi, 1'b0}
                  + {4'b0000, w_lo};
        end
    end

endmodule

// File: rtl/rtc_lector_bus.sv
// RTC AD-bus read sequencer: ALE address, turnaround, RD strobe, capture.
// Optional BCD decode of the captured byte with RTC_BCD2BIN_EN.
module rtc_lector_bus
    import rtc_bus_pkg::*;
#(
    parameter int T_ADDR = T_ADDR_D,
    parameter int T_RD   = T_RD_D,
    parameter int T_REC  = T_REC_D,
    parameter int CNT_W  = CNT_W_D
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] addr,
    input  logic [7:0] ad_in,
    output logic [7:0] ad_out,
    output logic       ad_oe,
    output logic       cs_n,
    output logic       rd_n,
    output logic       wr_n,
    output logic       ale,
    output logic       busy,
    output logic [7:0] dato,
    output logic       dato_valido
);

    state_t            r_state;
    state_t            w_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_lim;
    logic [7:0]        r_addr;
    logic [7:0]        w_addr_nxt;
    logic [7:0]        w_conv;
    logic              w_done;
    logic              w_acc;
    logic              w_cap;
    logic              w_drv;

`ifdef RTC_BCD2BIN_EN
    rtc_bcd2bin u_bcd (
        .i_bcd (ad_in),
        .o_bin (w_conv)
    );
`else
    assign w_conv = ad_in;
`endif

    always_comb begin
        w_lim = '0;
        unique case (r_state)
            ADDR:    w_lim = CNT_W'(T_ADDR - 1);
            READ:    w_lim = CNT_W'(T_RD - 1);
            REC:     w_lim = CNT_W'(T_REC - 1);
            default: w_lim = '0;
        endcase
    end

    assign w_done     = (r_cnt == w_lim);
    assign w_acc      = (r_state == IDLE) && start;
    assign w_cap      = (r_state == READ) && w_done;
    assign w_addr_nxt = w_acc ? addr : r_addr;

    always_comb begin
        w_nxt = r_state;
        unique case (r_state)
            IDLE:    if (start)  w_nxt = ADDR;
            ADDR:    if (w_done) w_nxt = HOLD;
            HOLD:    w_nxt = TURN;
            TURN:    w_nxt = READ;
            READ:    if (w_done) w_nxt = REC;
            REC:     if (w_done) w_nxt = IDLE;
            default: w_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nxt;
        end
    end

    assign w_drv = (w_nxt == ADDR) || (w_nxt == HOLD);

    // Outputs decoded from the next state so they line up with it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt       <= '0;
            r_addr      <= BUS_IDLE;
            cs_n        <= 1'b1;
            rd_n        <= 1'b1;
            wr_n        <= 1'b1;
            ale         <= 1'b0;
            ad_oe       <= 1'b0;
            ad_out      <= BUS_IDLE;
            busy        <= 1'b0;
            dato        <= 8'h00;
            dato_valido <= 1'b0;
        end else begin
            if (w_nxt != r_state || r_state == IDLE) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
            r_addr      <= w_addr_nxt;
            cs_n        <= (w_nxt == IDLE) || (w_nxt == REC);
            rd_n        <= (w_nxt != READ);
            wr_n        <= 1'b1;
            ale         <= (w_nxt == ADDR);
            ad_oe       <= w_drv;
            ad_out      <= w_drv ? w_addr_nxt : BUS_IDLE;
            busy        <= (w_nxt != IDLE);
            dato_valido <= w_cap;
            if (w_cap) begin
                dato <= w_conv;
            end
        end
    end

endmodule
